// File: rtl/watch_time_reporter.sv
// watch_time_reporter: snapshots watch time and streams "HH:MM:SS.CC\r\n" over a byte valid/ready handshake
module watch_time_reporter #(
  parameter int BIT_100HZ = 100,
  parameter int SECOND_60 = 60,
  parameter int HOUR      = 24
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(BIT_100HZ)-1:0] msec,
  input  logic [$clog2(SECOND_60)-1:0] sec,
  input  logic [$clog2(SECOND_60)-1:0] min,
  input  logic [$clog2(HOUR)-1:0]      hour,
  input  logic                         tick_1s,
  input  logic                         i_req,
  input  logic                         auto_en,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  output logic                         busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_state_nxt;
  logic [3:0] r_idx, w_idx_nxt;
  logic r_pending, w_pending_nxt;
  logic w_trig, w_load;
  logic [$clog2(HOUR)-1:0]      r_hour;
  logic [$clog2(SECOND_60)-1:0] r_min, r_sec;
  logic [$clog2(BIT_100HZ)-1:0] r_msec;
  logic [15:0] w_h, w_m, w_s, w_c;
  logic [7:0] w_byte;
  // two ASCII digits, saturating at "99" for values that do not fit
  function automatic logic [15:0] to_ascii(input logic [6:0] v);
    logic [6:0] s, t, u;
    s = (v > 7'd99) ? 7'd99 : v;
    t = s / 7'd10;
    u = s % 7'd10;
    return {8'h30 + {1'b0, t}, 8'h30 + {1'b0, u}};
  endfunction
  always_comb begin
    w_trig        = i_req | (auto_en & tick_1s);
    w_load        = (r_state == IDLE) & (w_trig | r_pending);
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_pending;
    if (w_load) begin
      w_state_nxt   = SEND;
      w_idx_nxt     = 4'd0;
      w_pending_nxt = 1'b0;
    end else if (r_state == SEND) begin
      w_pending_nxt = r_pending | w_trig;
      if (tx_ready) begin
        w_idx_nxt   = (r_idx == 4'd12) ? 4'd0 : r_idx + 4'd1;
        w_state_nxt = (r_idx == 4'd12) ? IDLE : SEND;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_idx     <= 4'd0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pending <= w_pending_nxt;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
      r_msec <= '0;
    end else if (w_load) begin
      r_hour <= hour;
      r_min  <= min;
      r_sec  <= sec;
      r_msec <= msec;
    end
  end
  assign w_h = to_ascii(7'(r_hour));
  assign w_m = to_ascii(7'(r_min));
  assign w_s = to_ascii(7'(r_sec));
  assign w_c = to_ascii(7'(r_msec));
  always_comb begin
    case (r_idx)
      4'd0:    w_byte = w_h[15:8];
      4'd1:    w_byte = w_h[7:0];
      4'd2:    w_byte = 8'h3A;
      4'd3:    w_byte = w_m[15:8];
      4'd4:    w_byte = w_m[7:0];
      4'd5:    w_byte = 8'h3A;
      4'd6:    w_byte = w_s[15:8];
      4'd7:    w_byte = w_s[7:0];
      4'd8:    w_byte = 8'h2E;
      4'd9:    w_byte = w_c[15:8];
      4'd10:   w_byte = w_c[7:0];
      4'd11:   w_byte = 8'h0D;
      4'd12:   w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end
  assign tx_valid = (r_state == SEND);
  assign busy     = tx_valid;
  assign tx_data  = tx_valid ? w_byte : 8'h00;
endmodule

// File: doc/watch_time_reporter.md
# watch_time_reporter

Transmit side of the watch's serial command path. It snapshots the running watch time (hour/min/sec/centisecond) and streams it as the 13-byte ASCII frame "HH:MM:SS.CC\r\n" to the UART transmit path through a byte-wide valid/ready handshake. A frame is sent on an explicit request, or every second when auto-report is enabled. It is the counterpart of the hour/min/sec set-command inputs that feed the watch datapath.

## Interface
- BIT_100HZ, 100: centisecond modulus; sizes msec.
- SECOND_60, 60: sec/min modulus; sizes sec and min.
- HOUR, 24: hour modulus; sizes hour.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- msec  in  $clog2(BIT_100HZ)  centiseconds from the watch datapath.
- sec  in  $clog2(SECOND_60)  seconds.
- min  in  $clog2(SECOND_60)  minutes.
- hour  in  $clog2(HOUR)  hours.
- tick_1s  in  1  one-cycle pulse each second from the watch datapath.
- i_req  in  1  one-cycle report request from the command decoder.
- auto_en  in  1  level; 1 = report on every tick_1s.
- tx_ready  in  1  UART TX path can accept a byte.
- tx_data  out  8  current frame byte.
- tx_valid  out  1  tx_data is valid.
- busy  out  1  frame in progress (state ≠ IDLE).

## Operation
- Trigger: i_req = 1, or (auto_en = 1 and tick_1s = 1). If both fire in the same cycle, only one frame is sent.
- FSM states: IDLE and SEND.
- IDLE → SEND on a trigger, or on pending = 1.
  - On that edge, hour/min/sec/msec are latched into snapshot registers.
  - The byte index is set to 0 and pending is cleared.
- SEND: a byte transfers on any edge where tx_valid = 1 and tx_ready = 1.
  - The index increments on each transfer.
  - A transfer at index 12 returns the FSM to IDLE.
- Frame byte order, index 0..12: H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0 0x0D 0x0A.
- Digits: tens = v/10, units = v%10, each sent as 0x30 + digit. ':' = 0x3A, '.' = 0x2E.
- Any input value ≥ 100 is sent as "99". The ≥ 100 case can only occur on msec, which is 7 bits.
- tx_data depends only on registered state (snapshot, index). It stays stable while tx_valid = 1 and tx_ready = 0.
- Triggers while in SEND set pending = 1. Any number of triggers during one frame coalesce into a single follow-up frame.
- Input changes after the snapshot do not affect the frame in flight.
- auto_en changes take effect on the next tick_1s. They never abort a frame.

## Timing
- Reset values:
  - tx_valid = 0, busy = 0, tx_data = 0x00.
  - Index = 0, pending = 0, snapshot = 0, state = IDLE.
- Asserting reset mid-frame drops tx_valid immediately (asynchronous) and discards the frame and pending request.
- Latency: trigger sampled at edge k → tx_valid = 1 and tx_data = H1 from edge k onward, i.e. the cycle after the trigger cycle.
- With tx_ready held at 1, the frame takes exactly 13 consecutive cycles.
- tx_valid never deasserts inside a frame until the final byte transfers.
- After the final transfer at edge j:
  - with pending = 0, the FSM returns to IDLE at edge j and tx_valid = 0 for at least one cycle;
  - with pending = 1, there is one IDLE cycle, then the new snapshot is taken at edge j+1.
- A trigger in the cycle of the final transfer sets pending; it is not lost.
- busy equals tx_valid.

## Test plan
- **Single request:** time 13:05:09.42, tx_ready = 1, one i_req pulse → tx_valid high one cycle later for 13 cycles. Bytes: 0x31 0x33 0x3A 0x30 0x35 0x3A 0x30 0x39 0x2E 0x34 0x32 0x0D 0x0A.
- **Backpressure and snapshot:** tx_ready = 0 for 5 cycles at index 3, and the time inputs change during the stall → tx_data holds 0x30 throughout. The frame completes with the original snapshot values.
- **Pending coalesce:** three i_req pulses during one frame → exactly two frames total. The second snapshot is taken one cycle after the first frame ends.
- **Auto report and simultaneity:** auto_en = 1, tick_1s every 200 cycles, tx_ready = 1 → one frame per tick. i_req coincident with tick_1s → still one frame.
- **Boundaries:** 23:59:59.99 → "23:59:59.99\r\n". Forced msec = 127 → C1 C0 = 0x39 0x39. 00:00:00.00 → all digit bytes 0x30.
- **Reset mid-frame:** reset = 0 at index 6 with pending = 1 → tx_valid = 0 and busy = 0 immediately. After release there is no output until the next trigger, whose frame starts at index 0.
